// File: rtl/sobel_frame_ctrl_if.sv
// Frame controller bus: video timing and switches in,
// frame-stable config, lock status and position strobes out.
interface sobel_frame_ctrl_if #(
    parameter int CNT_W = 12
);
    logic [7:0]       sw_i;
    logic             dv_i;
    logic             hs_i;
    logic             vs_i;
    logic [2:0]       mode_o;
    logic [4:0]       thresh_o;
    logic             bypass_o;
    logic             locked_o;
    logic             err_o;
    logic             frame_start_o;
    logic             line_start_o;
    logic [CNT_W-1:0] h_pos_o;
    logic [CNT_W-1:0] v_pos_o;

    modport master (
        output sw_i, dv_i, hs_i, vs_i,
        input  mode_o, thresh_o, bypass_o, locked_o, err_o,
        input  frame_start_o, line_start_o, h_pos_o, v_pos_o
    );

    modport slave (
        input  sw_i, dv_i, hs_i, vs_i,
        output mode_o, thresh_o, bypass_o, locked_o, err_o,
        output frame_start_o, line_start_o, h_pos_o, v_pos_o
    );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Frame-level controller for the Sobel datapath: geometry lock,
// bypass control, frame-boundary config and position counters.
module sobel_frame_ctrl #(
    parameter int SCREENWIDTH  = 64,
    parameter int SCREENHEIGHT = 64,
    parameter bit POL_VS       = 1'b1,
    parameter bit POL_HS       = 1'b1,
    parameter int LOCK_FRAMES  = 2,
    parameter int CNT_W        = 12
) (
    input logic              clk,
    input logic              rst,
    sobel_frame_ctrl_if.slave bus
);
    localparam logic [1:0] S_SEARCH  = 2'd0;
    localparam logic [1:0] S_MEASURE = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(SCREENWIDTH - 1);
    localparam logic [CNT_W:0]   N_LINES  = (CNT_W + 1)'(SCREENHEIGHT);
    localparam logic [3:0]       LOCK_N   = 4'(LOCK_FRAMES);

    logic             vs_q;
    logic             dv_q;
    logic             skip_q;
    logic             bad_q;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [3:0]       good_q;
    logic [3:0]       good_d;
    logic             err_d;
    logic [7:0]       sw_s1;
    logic [7:0]       sw_s2;
    logic [7:0]       sw_sh;
    logic [CNT_W-1:0] h_q;
    logic [CNT_W-1:0] v_q;

    logic             vs_act;
    logic             hs_act;
    logic             frame_edge;
    logic             run_start;
    logic             run_end;
    logic             width_bad;
    logic [CNT_W:0]   lines_seen;
    logic             frame_good;
    logic [3:0]       good_inc;

    // Edge detection and frame verdict from the current inputs.
    // A run still open at the frame edge counts as a line of the
    // old frame; its tail is then ignored (skip_q).
    always_comb begin
        vs_act     = (bus.vs_i == POL_VS);
        hs_act     = (bus.hs_i == POL_HS);
        frame_edge = vs_act & ~vs_q;
        run_start  = bus.dv_i & ~dv_q;
        run_end    = ~bus.dv_i & dv_q & ~skip_q;
        width_bad  = run_end & (h_q != LAST_PIX);
        lines_seen = {1'b0, v_q}
                   + (CNT_W + 1)'(run_end)
                   + (CNT_W + 1)'(bus.dv_i & ~skip_q);
        frame_good = ~bad_q & ~width_bad & (lines_seen == N_LINES);
        good_inc   = good_q + 4'd1;
    end

    // Lock state machine, judged only on frame edges.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_d   = 1'b0;
        case (state_q)
            S_SEARCH: begin
                if (frame_edge) begin
                    state_d = S_MEASURE;
                    good_d  = 4'd0;
                end
            end
            S_MEASURE: begin
                if (frame_edge) begin
                    if (frame_good) begin
                        good_d = good_inc;
                        if (good_inc >= LOCK_N) state_d = S_LOCKED;
                    end else begin
                        good_d = 4'd0;
                        err_d  = 1'b1;
                    end
                end
            end
            S_LOCKED: begin
                if (frame_edge && !frame_good) begin
                    state_d = S_MEASURE;
                    good_d  = 4'd0;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_SEARCH;
                good_d  = 4'd0;
            end
        endcase
    end

    // Input history and frame-boundary strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q              <= 1'b0;
            dv_q              <= 1'b0;
            bus.frame_start_o <= 1'b0;
            bus.line_start_o  <= 1'b0;
        end else begin
            vs_q              <= vs_act;
            dv_q              <= bus.dv_i;
            bus.frame_start_o <= frame_edge;
            bus.line_start_o  <= run_start & ~hs_act;
        end
    end

    // Saturating pixel and line position counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            if (run_start)
                h_q <= '0;
            else if (bus.dv_i && h_q != CNT_MAX)
                h_q <= h_q + 1'b1;
            if (frame_edge)
                v_q <= '0;
            else if (run_end && v_q != CNT_MAX)
                v_q <= v_q + 1'b1;
        end
    end

    // Frame-bad flag and straddling-run tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            skip_q <= 1'b0;
            bad_q  <= 1'b0;
        end else begin
            if (frame_edge && bus.dv_i)
                skip_q <= 1'b1;
            else if (!bus.dv_i)
                skip_q <= 1'b0;
            if (frame_edge)
                bad_q <= 1'b0;
            else if (width_bad)
                bad_q <= 1'b1;
        end
    end

    // FSM registers; lock and bypass follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_SEARCH;
            good_q       <= 4'd0;
            bus.err_o    <= 1'b0;
            bus.locked_o <= 1'b0;
            bus.bypass_o <= 1'b1;
        end else begin
            state_q      <= state_d;
            good_q       <= good_d;
            bus.err_o    <= err_d;
            bus.locked_o <= (state_d == S_LOCKED);
            bus.bypass_o <= (state_d != S_LOCKED);
        end
    end

    // Switch sync into a shadow; outputs load only at frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1        <= 8'd0;
            sw_s2        <= 8'd0;
            sw_sh        <= 8'd0;
            bus.mode_o   <= 3'd0;
            bus.thresh_o <= 5'd0;
        end else begin
            sw_s1 <= bus.sw_i;
            sw_s2 <= sw_s1;
            sw_sh <= sw_s2;
            if (frame_edge) begin
                bus.mode_o   <= sw_sh[2:0];
                bus.thresh_o <= sw_sh[7:3];
            end
        end
    end

    assign bus.h_pos_o = h_q;
    assign bus.v_pos_o = v_q;
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl: nominal lock, config,
// short line, tall frame, straddling edge and vs polarity.
module tb_sobel_frame_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    sobel_frame_ctrl_if #(.CNT_W(12)) i0 ();
    sobel_frame_ctrl_if #(.CNT_W(12)) i1 ();

    sobel_frame_ctrl #(.POL_VS(1'b1)) dut0 (
        .clk(clk), .rst(rst), .bus(i0)
    );
    sobel_frame_ctrl #(.POL_VS(1'b0)) dut1 (
        .clk(clk), .rst(rst), .bus(i1)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    bit   mon_en = 1'b0;
    int   fs_cnt, err_cnt, ls_cnt, max_h, max_v;
    int   lock_fs, err_fs, lock_nofs, err_nofs;
    int   byp_mm, cfg_nofs, pol_mm, ls_h_bad;
    logic lock_prev;
    logic [7:0] cfg_prev;

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    // Event recorder on dut0, plus dut1 equivalence tracking.
    always @(negedge clk) begin
        if (mon_en) begin
            if (i0.frame_start_o) fs_cnt++;
            if (i0.err_o) begin
                err_cnt++;
                err_fs = fs_cnt;
                if (!i0.frame_start_o) err_nofs++;
            end
            if (i0.line_start_o) begin
                ls_cnt++;
                if (i0.h_pos_o !== 12'd0) ls_h_bad++;
            end
            if (int'(i0.h_pos_o) > max_h) max_h = int'(i0.h_pos_o);
            if (int'(i0.v_pos_o) > max_v) max_v = int'(i0.v_pos_o);
            if (i0.locked_o !== lock_prev) begin
                if (!i0.frame_start_o) lock_nofs++;
                if (i0.locked_o) lock_fs = fs_cnt;
            end
            lock_prev = i0.locked_o;
            if (i0.bypass_o !== ~i0.locked_o) byp_mm++;
            if ({i0.thresh_o, i0.mode_o} !== cfg_prev
                && !i0.frame_start_o) cfg_nofs++;
            cfg_prev = {i0.thresh_o, i0.mode_o};
            if ({i1.mode_o, i1.thresh_o, i1.bypass_o, i1.locked_o,
                 i1.err_o, i1.frame_start_o, i1.line_start_o,
                 i1.h_pos_o, i1.v_pos_o} !==
                {i0.mode_o, i0.thresh_o, i0.bypass_o, i0.locked_o,
                 i0.err_o, i0.frame_start_o, i0.line_start_o,
                 i0.h_pos_o, i0.v_pos_o}) pol_mm++;
        end
    end

    task automatic cyc(input logic dv, input logic hs, input logic vs);
        i0.dv_i = dv; i1.dv_i = dv;
        i0.hs_i = hs; i1.hs_i = hs;
        i0.vs_i = vs; i1.vs_i = ~vs;
        @(posedge clk);
        #1;
    endtask

    task automatic set_sw(input logic [7:0] v);
        i0.sw_i = v;
        i1.sw_i = v;
    endtask

    // 83-clk line: 64 visible max, fp 3, sync 13, bp 3.
    task automatic line(input int w, input logic vs);
        for (int c = 0; c < 83; c++)
            cyc(c < w, (c >= 67 && c < 80), vs);
    endtask

    task automatic frame(input int n, input int sidx, input int sw);
        line(0, 1'b1);
        for (int i = 0; i < n; i++)
            line((i == sidx) ? sw : 64, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_sw(8'($urandom));
            cyc(1'($urandom), 1'($urandom), 1'($urandom));
            n_chk += 5;
            if (i0.bypass_o !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_bypass got %b need 1", i0.bypass_o);
            end
            if (i0.locked_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_locked got %b need 0", i0.locked_o);
            end
            if (i0.mode_o !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_mode got %0d need 0", i0.mode_o);
            end
            if (i0.h_pos_o !== 12'd0) begin
                n_fail++;
                $display("FAIL reset_hpos got %0d need 0", i0.h_pos_o);
            end
            if (i0.v_pos_o !== 12'd0) begin
                n_fail++;
                $display("FAIL reset_vpos got %0d need 0", i0.v_pos_o);
            end
        end
        set_sw(8'h00);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        fs_cnt = 0; err_cnt = 0; ls_cnt = 0; max_h = 0; max_v = 0;
        lock_fs = -1; err_fs = -1; lock_nofs = 0; err_nofs = 0;
        byp_mm = 0; cfg_nofs = 0; pol_mm = 0; ls_h_bad = 0;
        lock_prev = i0.locked_o;
        cfg_prev = {i0.thresh_o, i0.mode_o};
        mon_en = 1'b1;
    endtask

    task automatic test_nominal;
        for (int i = 0; i < 10; i++) line(64, 1'b0);
        frame(64, -1, 64);
        frame(64, -1, 64);
        frame(64, -1, 64);
        n_chk += 7;
        if (err_cnt !== 0) begin
            n_fail++;
            $display("FAIL nom_err got %0d pulses need 0", err_cnt);
        end
        if (lock_fs !== 3) begin
            n_fail++;
            $display("FAIL nom_lock_fs got %0d need 3", lock_fs);
        end
        if (i0.locked_o !== 1'b1 || i0.bypass_o !== 1'b0) begin
            n_fail++;
            $display("FAIL nom_locked got %b/%b need 1/0",
                     i0.locked_o, i0.bypass_o);
        end
        if (max_h !== 63) begin
            n_fail++;
            $display("FAIL nom_max_h got %0d need 63", max_h);
        end
        if (max_v !== 64) begin
            n_fail++;
            $display("FAIL nom_max_v got %0d need 64", max_v);
        end
        if (ls_cnt !== 202) begin
            n_fail++;
            $display("FAIL nom_line_starts got %0d need 202", ls_cnt);
        end
        if (fs_cnt !== 3) begin
            n_fail++;
            $display("FAIL nom_frame_starts got %0d need 3", fs_cnt);
        end
    endtask

    task automatic test_switch;
        set_sw(8'h04);
        for (int k = 0; k < 20; k++) cyc(1'b0, 1'b0, 1'b0);
        n_chk += 3;
        if (i0.mode_o !== 3'd0 || i0.thresh_o !== 5'd0) begin
            n_fail++;
            $display("FAIL sw_early got %0d/%0d need 0/0",
                     i0.mode_o, i0.thresh_o);
        end
        frame(64, -1, 64);
        if (i0.mode_o !== 3'd4 || i0.thresh_o !== 5'd0) begin
            n_fail++;
            $display("FAIL sw_loaded got %0d/%0d need 4/0",
                     i0.mode_o, i0.thresh_o);
        end
        if (i0.locked_o !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_locked got %b need 1", i0.locked_o);
        end
    endtask

    task automatic test_short_line;
        frame(64, 10, 63);
        frame(64, -1, 64);
        n_chk += 4;
        if (err_cnt !== 1 || err_fs !== 6) begin
            n_fail++;
            $display("FAIL short_err got %0d@fs%0d need 1@fs6",
                     err_cnt, err_fs);
        end
        if (i0.locked_o !== 1'b0 || i0.bypass_o !== 1'b1) begin
            n_fail++;
            $display("FAIL short_unlock got %b/%b need 0/1",
                     i0.locked_o, i0.bypass_o);
        end
        frame(64, -1, 64);
        if (i0.locked_o !== 1'b0) begin
            n_fail++;
            $display("FAIL short_one_good got %b need 0", i0.locked_o);
        end
        frame(64, -1, 64);
        if (i0.locked_o !== 1'b1 || lock_fs !== 8) begin
            n_fail++;
            $display("FAIL short_relock got %b@fs%0d need 1@fs8",
                     i0.locked_o, lock_fs);
        end
    endtask

    task automatic test_tall_frame;
        frame(65, -1, 64);
        line(0, 1'b1);
        for (int i = 0; i < 63; i++) line(64, 1'b0);
        n_chk += 5;
        if (err_cnt !== 2 || err_fs !== 10) begin
            n_fail++;
            $display("FAIL tall_err got %0d@fs%0d need 2@fs10",
                     err_cnt, err_fs);
        end
        if (i0.locked_o !== 1'b0) begin
            n_fail++;
            $display("FAIL tall_unlock got %b need 0", i0.locked_o);
        end
        for (int c = 0; c < 83; c++)
            cyc(c < 64, (c >= 67 && c < 80), c >= 30);
        for (int i = 0; i < 64; i++) line(64, 1'b0);
        if (i0.v_pos_o !== 12'd64) begin
            n_fail++;
            $display("FAIL straddle_vpos got %0d need 64", i0.v_pos_o);
        end
        line(0, 1'b1);
        if (i0.locked_o !== 1'b1 || lock_fs !== 12) begin
            n_fail++;
            $display("FAIL straddle_lock got %b@fs%0d need 1@fs12",
                     i0.locked_o, lock_fs);
        end
        if (err_cnt !== 2 || fs_cnt !== 12) begin
            n_fail++;
            $display("FAIL straddle_counts got err%0d fs%0d need err2 fs12",
                     err_cnt, fs_cnt);
        end
    endtask

    task automatic test_global;
        n_chk += 6;
        if (ls_cnt !== 715) begin
            n_fail++;
            $display("FAIL total_line_starts got %0d need 715", ls_cnt);
        end
        if (ls_h_bad !== 0) begin
            n_fail++;
            $display("FAIL ls_hpos got %0d bad need 0", ls_h_bad);
        end
        if (lock_nofs !== 0 || err_nofs !== 0) begin
            n_fail++;
            $display("FAIL edge_align got lock%0d err%0d need 0/0",
                     lock_nofs, err_nofs);
        end
        if (byp_mm !== 0) begin
            n_fail++;
            $display("FAIL bypass_vs_lock got %0d need 0", byp_mm);
        end
        if (cfg_nofs !== 0) begin
            n_fail++;
            $display("FAIL cfg_midframe got %0d need 0", cfg_nofs);
        end
        if (pol_mm !== 0 || i1.locked_o !== 1'b1) begin
            n_fail++;
            $display("FAIL polarity got %0d diffs lock %b need 0 lock 1",
                     pol_mm, i1.locked_o);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_switch();
        test_short_line();
        test_tall_frame();
        test_global();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sobel_frame_ctrl.md
Name: sobel_frame_ctrl

Overview:
Frame-level controller in front of the Sobel datapath. It watches the incoming video timing (dv/hs/vs) and measures frame geometry against SCREENWIDTH x SCREENHEIGHT. It declares lock after LOCK_FRAMES consecutive good frames, holds the datapath in bypass while unlocked, and applies switch-selected configuration only at frame boundaries. It also provides pixel and line position counters and frame/line start strobes for downstream filter sequencing.

Parameters:
SCREENWIDTH, 64, expected dv-high pixels per line
SCREENHEIGHT, 64, expected dv-high lines per frame
POL_VS, 1, active level of vs_i
POL_HS, 1, active level of hs_i (used only for line_start_o gating)
LOCK_FRAMES, 2, consecutive good frames required for lock (1..15)
CNT_W, 12, width of position/geometry counters

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
sw_i  in  8  config switches: [2:0] mode, [7:3] threshold
dv_i  in  1  data valid
hs_i  in  1  horizontal sync
vs_i  in  1  vertical sync
mode_o  out  3  frame-stable mode for datapath
thresh_o  out  5  frame-stable threshold for datapath
bypass_o  out  1  1 = datapath must pass video through unfiltered
locked_o  out  1  geometry lock status
err_o  out  1  one-cycle pulse: a measured frame failed geometry check
frame_start_o  out  1  one-cycle pulse on active vs edge
line_start_o  out  1  one-cycle pulse on first dv-high cycle of a line
h_pos_o  out  CNT_W  pixel index within current line
v_pos_o  out  CNT_W  line index within current frame

Behaviour:
- Reset (rst=1 at a clk edge): mode_o=0, thresh_o=0, bypass_o=1, locked_o=0, err_o=0, strobes=0, h_pos_o=0, v_pos_o=0, state=SEARCH, good count=0, vs/dv history regs=inactive. sw double-flop sync regs cleared. Reset mid-frame discards all measurement.
- dv_i/hs_i/vs_i are registered once; all strobes/positions carry exactly 1 cycle latency relative to the inputs.
- vs active = (vs_i == POL_VS). Frame edge = inactive->active transition. frame_start_o pulses for 1 cycle 1 cycle after the first active-sampled cycle.
- Line run = contiguous dv-high cycles. line_start_o is asserted on the first cycle of a run. h_pos_o = 0 on the first pixel and increments per dv-high cycle. Hold h_pos_o during dv low; clear it on the next line start.
- v_pos_o = number of completed runs since frame start. Clear it on frame start.
- Counters saturate at all-ones and never wrap.
- Width check at the end of each run (dv 1->0): width != SCREENWIDTH sets the frame-bad flag.
- FSM:
  SEARCH: wait for a frame edge, then go to MEASURE. Clear the bad flag. The partial frame before the first edge is never judged.
  MEASURE: on each frame edge, judge the completed frame. Good = no bad flag and line count == SCREENHEIGHT. Good increments the good count; on reaching LOCK_FRAMES go to LOCKED. Bad clears the good count and pulses err_o.
  LOCKED: on each frame edge, judge the same way. Bad drops to MEASURE with good=0, pulses err_o, and deasserts locked_o.
- locked_o=1 only in LOCKED. bypass_o = ~locked_o, updated with locked_o in the same cycle as frame_start_o.
- Config: sw_i passes through a 2-flop synchronizer into a shadow register every cycle. mode_o/thresh_o load the shadow value only in the frame_start_o cycle. A switch change mid-frame is invisible until the next frame start.
- A frame edge coinciding with dv high still counts as a frame edge. The in-progress run is judged in the old frame; the new frame starts measuring from the next run.
- Polarity: with POL_VS=0 an active-low vs produces the identical sequence.

Test Plan:
- Reset: hold rst 3 cycles with random inputs -> bypass_o=1, locked_o=0, mode_o=0, h_pos_o=v_pos_o=0 throughout.
- Nominal 64x64 timing (line total 83 clk: 64 visible, front porch 3, sync 13, back porch 3) -> err_o never pulses. locked_o rises at the 3rd frame_start_o (1 partial + 2 good). bypass_o falls in the same cycle. Max h_pos_o=63, v_pos_o reaches 64.
- Switch change sw_i=8'h04 mid-frame while locked -> mode_o=3'd4, thresh_o=0 only at the next frame_start_o, not earlier.
- Locked, one line shortened to 63 pixels -> err_o pulses at the next frame edge, locked_o=0, bypass_o=1. Relock after 2 further good frames.
- Frame of 65 lines -> err_o pulse and good count reset. Frame edge asserted during dv high -> counted as a frame edge, the run judged in the old frame.
- POL_VS=0 instance with inverted vs -> identical lock timing and strobes as the nominal case.
